// File: rtl/page_buf_sched.sv
// page_buf_sched: ownership scheduler for the single-page host/NAND buffer.
// Grants the buffer to one side at a time, keeps fill-before-drain ordering,
// counts words per burst and gates the buffer port strobes.
// Optional feature macro: PAGE_BUF_SCHED_TIMEOUT_EN (stall timeout abort).
module page_buf_sched #(
   parameter int PAGE_WORDS  = 2048,
   parameter int DW          = 16,
   parameter int CW          = $clog2(PAGE_WORDS) + 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          h_req,
   input  logic          h_wr,
   input  logic          h_stb,
   output logic          h_gnt,
   output logic          h_done,
   output logic          h_err,
   input  logic          n_req,
   input  logic          n_wr,
   input  logic          n_stb,
   output logic          n_gnt,
   output logic          n_done,
   output logic          n_err,
   output logic          b_hsel,
   output logic          b_hwe,
   output logic          b_hre,
   output logic          b_csel,
   output logic          b_cwe,
   output logic          b_cre,
   output logic [CW-1:0] wcnt,
   output logic [1:0]    buf_st
);

   typedef enum logic [2:0] {IDLE, H_FILL, H_DRAIN, N_FILL, N_DRAIN} state_t;

   localparam logic [1:0]    ST_EMPTY  = 2'd0;
   localparam logic [1:0]    ST_HOST   = 2'd1;
   localparam logic [1:0]    ST_NAND   = 2'd2;
   localparam logic [CW-1:0] LAST_WORD = CW'(PAGE_WORDS - 1);

   state_t        state_reg;
   logic          h_gnt_reg, n_gnt_reg;
   logic          h_done_reg, n_done_reg;
   logic          h_err_reg, n_err_reg;
   logic          prio_n_reg;      // 1: NAND side wins the next contested grant
   logic [CW-1:0] wcnt_reg;
   logic [1:0]    buf_st_reg;

   logic          own_host;
   logic          own_req;
   logic          own_stb;
   logic          last_word;
   logic          h_elig, n_elig;
   logic          h_win, n_win;
   logic          stall_abort;
   logic [1:0]    buf_st_next;

   // Owner view of the active burst and the content left behind on completion
   always_comb begin
      own_host    = (state_reg == H_FILL) || (state_reg == H_DRAIN);
      own_req     = own_host ? h_req : n_req;
      own_stb     = own_host ? h_stb : n_stb;
      last_word   = (wcnt_reg == LAST_WORD);
      buf_st_next = ST_EMPTY;
      case (state_reg)
         H_FILL:  buf_st_next = ST_HOST;
         N_FILL:  buf_st_next = ST_NAND;
         default: buf_st_next = ST_EMPTY;
      endcase
   end

   // Eligibility (fill needs EMPTY, drain needs the other side's data) and round-robin pick
   always_comb begin
      h_elig = h_req && (h_wr ? (buf_st_reg == ST_EMPTY) : (buf_st_reg == ST_NAND));
      n_elig = n_req && (n_wr ? (buf_st_reg == ST_EMPTY) : (buf_st_reg == ST_HOST));
      h_win  = h_elig && (!n_elig || !prio_n_reg);
      n_win  = n_elig && !h_win;
   end

`ifdef PAGE_BUF_SCHED_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYC + 1);
   logic [SW-1:0] stall_reg;

   // Consecutive owner-idle cycles inside a burst; cleared by any owner strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_reg <= '0;
      end else if ((state_reg == IDLE) || own_stb) begin
         stall_reg <= '0;
      end else begin
         stall_reg <= stall_reg + SW'(1);
      end
   end

   assign stall_abort = !own_stb && (stall_reg == SW'(TIMEOUT_CYC - 1));
`else
   assign stall_abort = 1'b0;
`endif

   // Scheduler FSM: arbitration in IDLE, word counting and completion/abort in bursts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         h_gnt_reg  <= 1'b0;
         n_gnt_reg  <= 1'b0;
         h_done_reg <= 1'b0;
         n_done_reg <= 1'b0;
         h_err_reg  <= 1'b0;
         n_err_reg  <= 1'b0;
         prio_n_reg <= 1'b0;
         wcnt_reg   <= '0;
         buf_st_reg <= ST_EMPTY;
      end else begin
         h_done_reg <= 1'b0;
         n_done_reg <= 1'b0;
         h_err_reg  <= 1'b0;
         n_err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               wcnt_reg <= '0;
               if (h_win) begin
                  state_reg <= h_wr ? H_FILL : H_DRAIN;
                  h_gnt_reg <= 1'b1;
               end else if (n_win) begin
                  state_reg <= n_wr ? N_FILL : N_DRAIN;
                  n_gnt_reg <= 1'b1;
               end
               // Only a contested grant moves the priority to the loser
               if (h_elig && n_elig) begin
                  prio_n_reg <= h_win;
               end
            end
            default: begin
               if (!own_req || stall_abort) begin
                  // Partial page is worthless: drop ownership and invalidate content
                  state_reg  <= IDLE;
                  h_gnt_reg  <= 1'b0;
                  n_gnt_reg  <= 1'b0;
                  wcnt_reg   <= '0;
                  buf_st_reg <= ST_EMPTY;
                  h_err_reg  <= own_host;
                  n_err_reg  <= !own_host;
               end else if (own_stb) begin
                  if (last_word) begin
                     state_reg  <= IDLE;
                     h_gnt_reg  <= 1'b0;
                     n_gnt_reg  <= 1'b0;
                     wcnt_reg   <= '0;
                     buf_st_reg <= buf_st_next;
                     h_done_reg <= own_host;
                     n_done_reg <= !own_host;
                  end else begin
                     wcnt_reg <= wcnt_reg + CW'(1);
                  end
               end
            end
         endcase
      end
   end

   // Port strobes: registered ownership gated with the owner's live strobe
   assign b_hsel = h_gnt_reg;
   assign b_hwe  = (state_reg == H_FILL)  && h_stb;
   assign b_hre  = (state_reg == H_DRAIN) && h_stb;
   assign b_csel = n_gnt_reg;
   assign b_cwe  = (state_reg == N_FILL)  && n_stb;
   assign b_cre  = (state_reg == N_DRAIN) && n_stb;

   assign h_gnt  = h_gnt_reg;
   assign n_gnt  = n_gnt_reg;
   assign h_done = h_done_reg;
   assign n_done = n_done_reg;
   assign h_err  = h_err_reg;
   assign n_err  = n_err_reg;
   assign wcnt   = wcnt_reg;
   assign buf_st = buf_st_reg;

endmodule

// File: doc/page_buf_sched.md
# page_buf_sched

Scheduler and ownership arbiter for the single-page data buffer between the host interface and the NAND-side controller. Grants exclusive buffer access to one side at a time, enforces fill-before-drain coherence, counts words per page burst, drives the buffer's per-side select/write/read strobes, and reports completion and abort status to both requesters.

## Interface
Parameters:
- PAGE_WORDS, 2048, words per page burst (buffer depth)
- DW, 16, data width (pass-through only, for documentation of attached buffer)
- CW, $clog2(PAGE_WORDS)+1, word counter width
- TIMEOUT_CYC, 1024, stall limit in cycles (used only with PAGE_BUF_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- h_req  in  1  host requests a page burst; held high until h_done/h_err
- h_wr  in  1  host direction: 1 = host fills buffer, 0 = host drains buffer; sampled with h_req
- h_stb  in  1  host word strobe, one word per high cycle
- h_gnt  out  1  host owns buffer
- h_done  out  1  one-cycle pulse, host burst complete
- h_err  out  1  one-cycle pulse, host burst aborted
- n_req, n_wr, n_stb, n_gnt, n_done, n_err  as above, NAND-controller side
- b_hsel, b_hwe, b_hre  out  1  buffer host-port select/write/read
- b_csel, b_cwe, b_cre  out  1  buffer controller-port select/write/read
- wcnt  out  CW  words transferred in current burst
- buf_st  out  2  buffer content: 0 EMPTY, 1 HOST_DATA, 2 NAND_DATA

## Operation
- FSM states: IDLE, H_FILL, H_DRAIN, N_FILL, N_DRAIN.
- Eligibility from IDLE: H_FILL needs h_req&h_wr&buf_st==EMPTY; N_DRAIN needs n_req&!n_wr&buf_st==HOST_DATA; N_FILL needs n_req&n_wr&buf_st==EMPTY; H_DRAIN needs h_req&!h_wr&buf_st==NAND_DATA.
- Ineligible requests stay pending, no grant, no error.
- Both eligible in same cycle (only possible at EMPTY): round-robin; priority bit favours the side that did not win last; reset value favours host.
- In a burst state: owner's gnt=1; b_*sel=1 for owner's port; b_*we or b_*re = owner's stb (combinational AND with registered state); other side's strobes ignored.
- wcnt increments on each accepted strobe; strobe with wcnt==PAGE_WORDS-1 completes burst.
- Completion: next cycle FSM→IDLE, gnt=0, done pulse, wcnt→0; buf_st: H_FILL→HOST_DATA, N_DRAIN→EMPTY, N_FILL→NAND_DATA, H_DRAIN→EMPTY.
- Owner drops req before completion: abort; next cycle FSM→IDLE, err pulse, wcnt→0, buf_st→EMPTY (partial data invalid).
- Strobes in IDLE ignored; wcnt never exceeds PAGE_WORDS-1.

## Timing
- Reset values: all gnt/done/err/b_* = 0, wcnt=0, buf_st=EMPTY, FSM=IDLE, priority=host.
- Grant latency: eligible req at edge k → gnt high after edge k+1 (registered); first strobe accepted same cycle gnt is high.
- Strobe-to-buffer: zero cycles (combinational gate).
- Burst of PAGE_WORDS back-to-back strobes: done pulses one cycle after last strobe; total req-to-done = PAGE_WORDS+2 cycles minimum.
- New grant earliest one cycle after done/err (IDLE re-arbitrates).
- rst_n assertion mid-burst: immediate return to reset values; buffer content treated EMPTY.

## Configuration
- PAGE_BUF_SCHED_TIMEOUT_EN defined: stall counter in burst states counts consecutive cycles with no owner strobe, cleared on strobe; reaching TIMEOUT_CYC aborts exactly as req-drop (err pulse, buf_st=EMPTY).
- Not defined: no stall counter; owner may stall indefinitely; TIMEOUT_CYC unused.

## Test plan
- PAGE_WORDS=8: host write req, 8 strobes → h_gnt 1 cycle after req, b_hwe 8 cycles, h_done at cycle 10, buf_st=HOST_DATA.
- Then NAND drain req, 8 strobes → b_cre 8 cycles, n_done, buf_st=EMPTY; host drain req meanwhile stays ungranted.
- Host write and NAND fill requested same cycle from reset → host granted; repeat after drain → NAND granted.
- Host drops h_req after 3 strobes → h_err pulse, wcnt=0, buf_st=EMPTY, no h_done.
- rst_n low at wcnt=5 in N_FILL → all outputs reset values immediately, buf_st=EMPTY.
- With PAGE_BUF_SCHED_TIMEOUT_EN, TIMEOUT_CYC=4: grant then 4 idle cycles → err pulse; without macro, 100 idle cycles → gnt still 1.
